// File: rtl/wb_spm_mac.sv
// wb_spm_mac: Wishbone classic slave wrapping a bit-serial unsigned
// WIDTH x WIDTH multiplier (one multiplier bit per clock) with optional
// accumulate into the product register, sticky done flag and level irq.
module wb_spm_mac #(
    parameter int          WIDTH     = 32,
    parameter logic [31:0] BASE_ADDR = 32'h3000_0000
) (
    input  logic        wb_clk_i,
    input  logic        wb_rst_i,
    input  logic        wbs_cyc_i,
    input  logic        wbs_stb_i,
    input  logic        wbs_we_i,
    input  logic [3:0]  wbs_sel_i,
    input  logic [31:0] wbs_adr_i,
    input  logic [31:0] wbs_dat_i,
    output logic [31:0] wbs_dat_o,
    output logic        wbs_ack_o,
    output logic        irq
);

    localparam int PW = 2 * WIDTH;
    localparam int CW = $clog2(WIDTH);

    localparam logic [5:0] OFF_X      = 6'h00;
    localparam logic [5:0] OFF_Y      = 6'h01;
    localparam logic [5:0] OFF_CTRL   = 6'h02;
    localparam logic [5:0] OFF_STATUS = 6'h03;
    localparam logic [5:0] OFF_P_LO   = 6'h04;
    localparam logic [5:0] OFF_P_HI   = 6'h05;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t          state_q, state_d;
    logic [WIDTH-1:0] x_q, x_d;
    logic [WIDTH-1:0] y_q, y_d;
    logic [WIDTH-1:0] y_sh_q, y_sh_d;
    logic [PW-1:0]    sum_q, sum_d;
    logic [PW-1:0]    p_q, p_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             acc_q, acc_d;
    logic             ie_q, ie_d;
    logic             done_q, done_d;
    logic             ack_q, ack_d;
    logic [31:0]      dat_o_q, dat_o_d;

    logic        busy;
    logic        req, hit, wr_en, rd_en;
    logic [5:0]  off;
    logic        start, clr, done_clr, done_set;
    logic [31:0] x_wr, y_wr;
    logic [PW-1:0] add_term, sum_nxt;
    logic [63:0] p_ext;

    // Address bits below word granularity play no part in decoding.
    logic unused_adr;
    assign unused_adr = ^wbs_adr_i[1:0];

    // Byte-lane merge of a bus write into an existing 32-bit register image.
    function automatic logic [31:0] byte_merge(input logic [31:0] old_v,
                                               input logic [31:0] new_v,
                                               input logic [3:0]  sel);
        logic [31:0] res;
        for (int b = 0; b < 4; b++) begin
            res[8*b +: 8] = sel[b] ? new_v[8*b +: 8] : old_v[8*b +: 8];
        end
        return res;
    endfunction

    assign busy      = (state_q == RUN);
    assign irq       = done_q & ie_q;
    assign wbs_ack_o = ack_q;
    assign wbs_dat_o = dat_o_q;
    assign p_ext     = 64'(p_q);

    // Bus decode, register updates, FSM next state and serial datapath.
    always_comb begin
        // NOTE: every signal gets a default before any branch so no latch is inferred.
        state_d  = state_q;
        x_d      = x_q;
        y_d      = y_q;
        y_sh_d   = y_sh_q;
        sum_d    = sum_q;
        p_d      = p_q;
        cnt_d    = cnt_q;
        acc_d    = acc_q;
        ie_d     = ie_q;
        done_d   = done_q;
        dat_o_d  = '0;
        start    = 1'b0;
        clr      = 1'b0;
        done_clr = 1'b0;
        done_set = 1'b0;

        // A request is sampled only while ack is low, giving single-cycle acks.
        req   = wbs_cyc_i & wbs_stb_i & ~ack_q;
        hit   = (wbs_adr_i[31:8] == BASE_ADDR[31:8]);
        off   = wbs_adr_i[7:2];
        wr_en = req & wbs_we_i & hit;
        rd_en = req & ~wbs_we_i & hit;
        ack_d = req;

        x_wr = byte_merge(32'(x_q), wbs_dat_i, wbs_sel_i);
        y_wr = byte_merge(32'(y_q), wbs_dat_i, wbs_sel_i);

        if (wr_en) begin
            case (off)
                OFF_X: if (!busy) x_d = x_wr[WIDTH-1:0];
                OFF_Y: if (!busy) y_d = y_wr[WIDTH-1:0];
                OFF_CTRL: begin
                    if (wbs_sel_i[0]) begin
                        acc_d = wbs_dat_i[1];
                        ie_d  = wbs_dat_i[2];
                        start = wbs_dat_i[0] & ~busy;
                        clr   = wbs_dat_i[3] & ~busy;
                    end
                end
                OFF_STATUS: done_clr = wbs_sel_i[0] & wbs_dat_i[1];
                default: ;
            endcase
        end

        // CLR only happens while idle, so it never races a completion.
        if (clr) begin
            p_d = '0;
        end

        add_term = y_sh_q[0] ? (PW'(x_q) << cnt_q) : '0;
        sum_nxt  = sum_q + add_term;

        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = RUN;
                    y_sh_d  = y_q;
                    // CLR in the same write zeroes the accumulate base.
                    sum_d   = (acc_d && !clr) ? p_q : '0;
                    cnt_d   = '0;
                end
            end
            RUN: begin
                sum_d  = sum_nxt;
                y_sh_d = y_sh_q >> 1;
                cnt_d  = cnt_q + CW'(1);
                if (cnt_q == CW'(WIDTH - 1)) begin
                    state_d  = IDLE;
                    p_d      = sum_nxt;
                    done_set = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase

        // Completion beats a simultaneous write-1-clear.
        if (done_set) begin
            done_d = 1'b1;
        end else if (start || done_clr) begin
            done_d = 1'b0;
        end

        if (rd_en) begin
            case (off)
                OFF_X:      dat_o_d = 32'(x_q);
                OFF_Y:      dat_o_d = 32'(y_q);
                OFF_CTRL:   dat_o_d = {28'b0, 1'b0, ie_q, acc_q, 1'b0};
                OFF_STATUS: dat_o_d = {30'b0, done_q, busy};
                OFF_P_LO:   dat_o_d = p_ext[31:0];
                OFF_P_HI:   dat_o_d = p_ext[63:32];
                default:    dat_o_d = '0;
            endcase
        end
    end

    // State and register flops; reset clears everything including in-flight acks.
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            state_q <= IDLE;
            x_q     <= '0;
            y_q     <= '0;
            y_sh_q  <= '0;
            sum_q   <= '0;
            p_q     <= '0;
            cnt_q   <= '0;
            acc_q   <= 1'b0;
            ie_q    <= 1'b0;
            done_q  <= 1'b0;
            ack_q   <= 1'b0;
            dat_o_q <= '0;
        end else begin
            // NOTE: non-blocking assignments so every flop samples pre-edge values.
            state_q <= state_d;
            x_q     <= x_d;
            y_q     <= y_d;
            y_sh_q  <= y_sh_d;
            sum_q   <= sum_d;
            p_q     <= p_d;
            cnt_q   <= cnt_d;
            acc_q   <= acc_d;
            ie_q    <= ie_d;
            done_q  <= done_d;
            ack_q   <= ack_d;
            dat_o_q <= dat_o_d;
        end
    end

endmodule
